// File: rtl/alu_sched_pkg.sv
// rtl/alu_sched_pkg.sv - shared types and control-word constants for the ALU round-robin scheduler
package alu_sched_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam int CTL_ZX = 5;
  localparam int CTL_NX = 4;
  localparam int CTL_ZY = 3;
  localparam int CTL_NY = 2;
  localparam int CTL_F  = 1;
  localparam int CTL_NO = 0;

  localparam logic [5:0] ADD    = 6'b000010;
  localparam logic [5:0] SUB_XY = 6'b010011;
  localparam logic [5:0] ZERO   = 6'b101010;
  localparam logic [5:0] NEG1   = 6'b111010;
  localparam logic [5:0] AND    = 6'b000000;

endpackage

// File: rtl/alu.sv
// rtl/alu.sv - Hack-style 16-bit combinational ALU shared by the scheduler
module alu (
  input  logic [15:0] x,
  input  logic [15:0] y,
  input  logic        zx,
  input  logic        nx,
  input  logic        zy,
  input  logic        ny,
  input  logic        f,
  input  logic        no,
  output logic [15:0] out,
  output logic        zr,
  output logic        ng
);

  logic [15:0] x_z, x_n, y_z, y_n, res;

  assign x_z = zx ? 16'h0000 : x;
  assign x_n = nx ? ~x_z : x_z;
  assign y_z = zy ? 16'h0000 : y;
  assign y_n = ny ? ~y_z : y_z;
  assign res = f ? (x_n + y_n) : (x_n & y_n);
  assign out = no ? ~res : res;
  assign zr  = (out == 16'h0000);
  assign ng  = out[15];

endmodule

// File: rtl/alu_rr_pick.sv
// rtl/alu_rr_pick.sv - two-way round-robin picker; on contention the requester other than last_id wins
module alu_rr_pick (
  input  logic valid0,
  input  logic valid1,
  input  logic last_id,
  output logic grant,
  output logic any
);

  assign any   = valid0 | valid1;
  assign grant = (valid0 & valid1) ? ~last_id : valid1;

endmodule

// File: rtl/alu_rr_scheduler.sv
// rtl/alu_rr_scheduler.sv - shares one ALU between two requesters; ALU_RR_STATS_EN adds per-requester grant counters
module alu_rr_scheduler
  import alu_sched_pkg::*;
#(
  parameter int ALU_LAT = 1
`ifdef ALU_RR_STATS_EN
  ,
  parameter int STAT_W = 16
`endif
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [15:0] req0_x,
  input  logic [15:0] req0_y,
  input  logic [5:0]  req0_ctl,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [15:0] req1_x,
  input  logic [15:0] req1_y,
  input  logic [5:0]  req1_ctl,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [15:0] rsp_out,
  output logic        rsp_zr,
  output logic        rsp_ng,
  output logic        rsp_id
`ifdef ALU_RR_STATS_EN
  ,
  input  logic              stat_clr,
  output logic [STAT_W-1:0] stat0,
  output logic [STAT_W-1:0] stat1
`endif
);

  if (ALU_LAT < 1 || ALU_LAT > 4) begin : g_bad_lat
    $error("alu_rr_scheduler: ALU_LAT must be in 1..4");
  end

  localparam logic [1:0] CNT_INIT = 2'(ALU_LAT - 1);

  state_t      state;
  logic        last_id;
  logic [15:0] lat_x, lat_y;
  logic [5:0]  lat_ctl;
  logic [1:0]  cnt;
  logic        grant, any, accept;
  logic [15:0] alu_out;
  logic        alu_zr, alu_ng;

  alu_rr_pick u_pick (
    .valid0  (req0_valid),
    .valid1  (req1_valid),
    .last_id (last_id),
    .grant   (grant),
    .any     (any)
  );

  // The ALU only ever sees latched operands, so requesters may change inputs after acceptance.
  alu u_alu (
    .x   (lat_x),
    .y   (lat_y),
    .zx  (lat_ctl[CTL_ZX]),
    .nx  (lat_ctl[CTL_NX]),
    .zy  (lat_ctl[CTL_ZY]),
    .ny  (lat_ctl[CTL_NY]),
    .f   (lat_ctl[CTL_F]),
    .no  (lat_ctl[CTL_NO]),
    .out (alu_out),
    .zr  (alu_zr),
    .ng  (alu_ng)
  );

  assign accept     = (state == IDLE) & any;
  assign req0_ready = (state == IDLE) & req0_valid & ~grant;
  assign req1_ready = (state == IDLE) & req1_valid & grant;
  assign rsp_valid  = (state == RESP);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      last_id <= 1'b1;
      lat_x   <= 16'h0000;
      lat_y   <= 16'h0000;
      lat_ctl <= 6'b000000;
      cnt     <= 2'd0;
      rsp_out <= 16'h0000;
      rsp_zr  <= 1'b0;
      rsp_ng  <= 1'b0;
      rsp_id  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            lat_x   <= grant ? req1_x : req0_x;
            lat_y   <= grant ? req1_y : req0_y;
            lat_ctl <= grant ? req1_ctl : req0_ctl;
            last_id <= grant;
            cnt     <= CNT_INIT;
            state   <= BUSY;
          end
        end
        BUSY: begin
          if (cnt == 2'd0) begin
            rsp_out <= alu_out;
            rsp_zr  <= alu_zr;
            rsp_ng  <= alu_ng;
            rsp_id  <= last_id;
            state   <= RESP;
          end else begin
            cnt <= cnt - 2'd1;
          end
        end
        RESP: begin
          if (rsp_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef ALU_RR_STATS_EN
  localparam logic [STAT_W-1:0] STAT_ONE = STAT_W'(1);

  // Clear takes priority over a same-cycle grant; counters stick at all-ones.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat0 <= '0;
      stat1 <= '0;
    end else if (stat_clr) begin
      stat0 <= '0;
      stat1 <= '0;
    end else begin
      if (accept & ~grant & ~(&stat0)) stat0 <= stat0 + STAT_ONE;
      if (accept & grant & ~(&stat1))  stat1 <= stat1 + STAT_ONE;
    end
  end
`endif

endmodule

// File: tb/tb_alu_rr_scheduler.sv
// tb/tb_alu_rr_scheduler.sv - self-checking bench for alu_rr_scheduler (ALU_LAT=3; stats checks when ALU_RR_STATS_EN)
module tb_alu_rr_scheduler;
  import alu_sched_pkg::*;

  localparam int LAT = 3;

  logic        clk, rst;
  logic        req0_valid, req0_ready, req1_valid, req1_ready;
  logic [15:0] req0_x, req0_y, req1_x, req1_y;
  logic [5:0]  req0_ctl, req1_ctl;
  logic        rsp_valid, rsp_ready, rsp_zr, rsp_ng, rsp_id;
  logic [15:0] rsp_out;
`ifdef ALU_RR_STATS_EN
  logic        stat_clr;
  logic [15:0] stat0, stat1;
`endif

  alu_rr_scheduler #(.ALU_LAT(LAT)) dut (
    .clk        (clk),
    .rst        (rst),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_x     (req0_x),
    .req0_y     (req0_y),
    .req0_ctl   (req0_ctl),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_x     (req1_x),
    .req1_y     (req1_y),
    .req1_ctl   (req1_ctl),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_out    (rsp_out),
    .rsp_zr     (rsp_zr),
    .rsp_ng     (rsp_ng),
    .rsp_id     (rsp_id)
`ifdef ALU_RR_STATS_EN
    ,
    .stat_clr   (stat_clr),
    .stat0      (stat0),
    .stat1      (stat1)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic        id;
    logic [15:0] x;
    logic [15:0] y;
    logic [5:0]  ctl;
    logic [15:0] out;
    logic        zr;
    logic        ng;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Hack ALU semantics as plain integer arithmetic on 0..65535.
  function automatic logic [15:0] alu_ref(input logic [15:0] x, input logic [15:0] y, input logic [5:0] c);
    int a, b, r;
    a = c[CTL_ZX] ? 0 : int'(x);
    if (c[CTL_NX]) a = 65535 - a;
    b = c[CTL_ZY] ? 0 : int'(y);
    if (c[CTL_NY]) b = 65535 - b;
    r = c[CTL_F] ? (a + b) % 65536 : (a & b);
    if (c[CTL_NO]) r = 65535 - r;
    return 16'(r);
  endfunction

  function automatic logic ready_of(input logic id);
    return id ? req1_ready : req0_ready;
  endfunction

  task automatic set_req(input logic id, input logic v, input logic [15:0] x, input logic [15:0] y,
                         input logic [5:0] c);
    if (id) begin
      req1_valid = v; req1_x = x; req1_y = y; req1_ctl = c;
    end else begin
      req0_valid = v; req0_x = x; req0_y = y; req0_ctl = c;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req0_valid = 0; req0_x = 0; req0_y = 0; req0_ctl = 0;
    req1_valid = 0; req1_x = 0; req1_y = 0; req1_ctl = 0;
    rsp_ready = 0;
`ifdef ALU_RR_STATS_EN
    stat_clr = 0;
`endif
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic wait_ready(input logic id);
    int k = 0;
    @(negedge clk);
    while (!ready_of(id) && k < 20) begin
      @(negedge clk);
      k++;
    end
    check("accept_ready", 32'(ready_of(id)), 32'd1);
  endtask

  task automatic wait_rsp(output int m);
    m = 0;
    @(negedge clk);
    while (!rsp_valid && m < 20) begin
      @(negedge clk);
      m++;
    end
  endtask

  task automatic run_single(input vec_t v);
    int m;
    @(posedge clk); #1;
    set_req(v.id, 1'b1, v.x, v.y, v.ctl);
    rsp_ready = 1'b1;
    wait_ready(v.id);
    check("other_ready", 32'(ready_of(~v.id)), 32'd0);
    @(posedge clk); #1;
    set_req(v.id, 1'b0, 16'h0, 16'h0, 6'h0);
    wait_rsp(m);
    check("latency", 32'(m), 32'(LAT));
    check("rsp_out", 32'(rsp_out), 32'(v.out));
    check("rsp_flags", {30'd0, rsp_zr, rsp_ng}, {30'd0, v.zr, v.ng});
    check("rsp_id", 32'(rsp_id), 32'(v.id));
    @(negedge clk);
    check("rsp_done", 32'(rsp_valid), 32'd0);
  endtask

  initial begin
    int m, ngr, nrs, last_g, cyc;
    int gid[4], gcyc[4], rid[4];
    logic [15:0] rout[4];

    vecs[0] = '{1'b0, 16'd5,    16'd7,    ADD,    16'h000C, 1'b0, 1'b0};
    vecs[1] = '{1'b1, 16'd3,    16'd10,   SUB_XY, 16'hFFF9, 1'b0, 1'b1};
    vecs[2] = '{1'b0, 16'h1234, 16'h5678, ZERO,   16'h0000, 1'b1, 1'b0};
    vecs[3] = '{1'b1, 16'hABCD, 16'h0001, NEG1,   16'hFFFF, 1'b0, 1'b1};
    vecs[4] = '{1'b0, 16'hF0F0, 16'h0FF0, AND,    16'h00F0, 1'b0, 1'b0};
    vecs[5] = '{1'b1, 16'd7,    16'd7,    SUB_XY, 16'h0000, 1'b1, 1'b0};

    do_reset();
    @(negedge clk);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rsp_out", 32'(rsp_out), 32'd0);
    check("rst_rsp_flags_id", {29'd0, rsp_zr, rsp_ng, rsp_id}, 32'd0);
    check("rst_readies", {30'd0, req0_ready, req1_ready}, 32'd0);

    for (int i = 0; i < 6; i++) run_single(vecs[i]);

    // Both requesters continuously valid from reset: strict alternation, issue interval LAT+2.
    do_reset();
    @(posedge clk); #1;
    set_req(1'b0, 1'b1, 16'd1, 16'd2, ADD);
    set_req(1'b1, 1'b1, 16'd9, 16'd4, SUB_XY);
    rsp_ready = 1'b1;
    ngr = 0; nrs = 0; cyc = 0;
    while ((ngr < 4 || nrs < 4) && cyc < 100) begin
      @(negedge clk);
      if ((req0_ready || req1_ready) && ngr < 4) begin
        gid[ngr] = req1_ready ? 1 : 0;
        gcyc[ngr] = cyc;
        ngr++;
      end
      if (rsp_valid && nrs < 4) begin
        rid[nrs] = int'(rsp_id);
        rout[nrs] = rsp_out;
        nrs++;
      end
      cyc++;
    end
    check("alt_grants_seen", 32'(ngr), 32'd4);
    check("alt_rsps_seen", 32'(nrs), 32'd4);
    for (int i = 0; i < 4; i++) begin
      check("alt_grant_id", 32'(gid[i]), 32'(i % 2));
      check("alt_rsp_id", 32'(rid[i]), 32'(i % 2));
      check("alt_rsp_out", 32'(rout[i]), (i % 2) ? 32'd5 : 32'd3);
      if (i > 0) check("alt_interval", 32'(gcyc[i] - gcyc[i-1]), 32'(LAT + 2));
    end
    @(posedge clk); #1;
    set_req(1'b0, 1'b0, 16'h0, 16'h0, 6'h0);
    set_req(1'b1, 1'b0, 16'h0, 16'h0, 6'h0);
    repeat (2) @(posedge clk);

    // Consumer stalls 5 cycles with req1 pending; response held, no readies.
    #1;
    set_req(1'b0, 1'b1, 16'h1234, 16'h5678, ZERO);
    rsp_ready = 1'b0;
    wait_ready(1'b0);
    @(posedge clk); #1;
    set_req(1'b0, 1'b0, 16'h0, 16'h0, 6'h0);
    set_req(1'b1, 1'b1, 16'd2, 16'd2, ADD);
    wait_rsp(m);
    for (int i = 0; i < 5; i++) begin
      check("hold_rsp", {13'd0, rsp_valid, rsp_out, rsp_zr, rsp_id, rsp_ng}, {13'd0, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b0});
      check("hold_readies", {30'd0, req0_ready, req1_ready}, 32'd0);
      @(negedge clk);
    end
    @(posedge clk); #1 rsp_ready = 1'b1;
    @(negedge clk);
    check("hold_last_cycle", 32'(rsp_valid), 32'd1);
    @(negedge clk);
    check("hold_released", 32'(rsp_valid), 32'd0);
    check("pending_req1_ready", 32'(req1_ready), 32'd1);
    @(posedge clk); #1;
    set_req(1'b1, 1'b0, 16'h0, 16'h0, 6'h0);
    wait_rsp(m);
    check("pending_req1_rsp", {15'd0, rsp_out, rsp_id}, {15'd0, 16'd4, 1'b1});
    @(negedge clk);

    // Reset while BUSY drops the operation entirely.
    @(posedge clk); #1;
    set_req(1'b0, 1'b1, 16'd5, 16'd7, ADD);
    wait_ready(1'b0);
    @(posedge clk); #1;
    set_req(1'b0, 1'b0, 16'h0, 16'h0, 6'h0);
    @(posedge clk); #1 rst = 1'b1;
    #1;
    check("busy_rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("busy_rst_rsp_out", 32'(rsp_out), 32'd0);
    @(posedge clk); #1 rst = 1'b0;
    for (int i = 0; i < LAT + 4; i++) begin
      @(negedge clk);
      check("busy_rst_no_rsp", 32'(rsp_valid), 32'd0);
    end
    run_single(vecs[0]);

    // Randomized traffic against a transaction-level model.
    begin
      logic        v[2], acc[2];
      logic [15:0] px[2], py[2];
      logic [5:0]  pc[2];
      logic [5:0]  named[5];
      logic        busy, clr_pend, mlast, g, er0, er1, exp_rv;
      int          acc_cyc;
      logic [18:0] exp_rsp;
      named[0] = ADD; named[1] = SUB_XY; named[2] = ZERO; named[3] = NEG1; named[4] = AND;
      do_reset();
      v[0] = 0; v[1] = 0; acc[0] = 0; acc[1] = 0;
      px[0] = 0; px[1] = 0; py[0] = 0; py[1] = 0; pc[0] = 0; pc[1] = 0;
      busy = 0; clr_pend = 0; mlast = 1; acc_cyc = 0; exp_rsp = '0; g = 0;
      for (int c = 0; c < 1500; c++) begin
        @(posedge clk); #1;
        if (clr_pend) begin busy = 0; clr_pend = 0; end
        for (int i = 0; i < 2; i++) begin
          if (acc[i]) begin v[i] = 0; acc[i] = 0; end
          if (!v[i] && $urandom_range(0, 2) == 0) begin
            v[i] = 1;
            px[i] = 16'($urandom);
            py[i] = 16'($urandom);
            pc[i] = ($urandom_range(0, 1) == 0) ? named[$urandom_range(0, 4)] : 6'($urandom);
          end
          set_req(1'(i), v[i], px[i], py[i], pc[i]);
        end
        rsp_ready = ($urandom_range(0, 3) != 0);
        @(negedge clk);
        er0 = 0; er1 = 0;
        if (!busy && (v[0] || v[1])) begin
          g = (v[0] && v[1]) ? ~mlast : v[1];
          er0 = ~g; er1 = g;
        end
        check("rnd_readies", {30'd0, req0_ready, req1_ready}, {30'd0, er0, er1});
        if (er0 || er1) begin
          acc[g] = 1; mlast = g; busy = 1; acc_cyc = c;
          exp_rsp[18:3] = alu_ref(px[g], py[g], pc[g]);
          exp_rsp[2] = (exp_rsp[18:3] == 16'h0000);
          exp_rsp[1] = exp_rsp[18];
          exp_rsp[0] = g;
        end
        exp_rv = busy && (c >= acc_cyc + LAT + 1);
        check("rnd_rsp_valid", 32'(rsp_valid), 32'(exp_rv));
        if (exp_rv && rsp_valid) begin
          check("rnd_rsp", {13'd0, rsp_out, rsp_zr, rsp_ng, rsp_id}, {13'd0, exp_rsp});
          if (rsp_ready) clr_pend = 1;
        end
      end
      @(posedge clk); #1;
      set_req(1'b0, 1'b0, 16'h0, 16'h0, 6'h0);
      set_req(1'b1, 1'b0, 16'h0, 16'h0, 6'h0);
    end

`ifdef ALU_RR_STATS_EN
    do_reset();
    run_single(vecs[0]);
    run_single(vecs[1]);
    run_single(vecs[2]);
    run_single(vecs[3]);
    run_single(vecs[4]);
    check("stat0_count", 32'(stat0), 32'd3);
    check("stat1_count", 32'(stat1), 32'd2);
    @(posedge clk); #1;
    set_req(1'b0, 1'b1, 16'd1, 16'd1, ADD);
    stat_clr = 1'b1;
    @(negedge clk);
    check("clr_accept_ready", 32'(req0_ready), 32'd1);
    @(posedge clk); #1;
    stat_clr = 1'b0;
    set_req(1'b0, 1'b0, 16'h0, 16'h0, 6'h0);
    @(negedge clk);
    check("stat_clr_wins", {stat0, stat1}, 32'd0);
    wait_rsp(m);
    @(negedge clk);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
